// File: rtl/ifetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// ifetch_unit_pkg
//   Shared definitions for the instruction fetch unit:
//   - INST_WIDTH : width of one instruction word returned by the ICache
//   - PC_STEP    : byte distance between sequential fetch addresses
//   - TRUE/FALSE : readable single-bit constants for control signals
//   - fetch_state_e : fetch FSM encoding
//       ST_IDLE : no ICache request outstanding
//       ST_WAIT : request outstanding, response will be queued
//       ST_DROP : request outstanding, response is stale and will be dropped
// -----------------------------------------------------------------------------
package ifetch_unit_pkg;

    localparam int INST_WIDTH = 32;
    localparam int PC_STEP    = 4;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/ifetch_unit_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
//   Synchronous, flushable FIFO used as the fetched-instruction queue.
//
//   Parameters
//     WIDTH : entry width in bits
//     DEPTH : number of entries, power of two, >= 2
//
//   Ports
//     clk        in   clock
//     rst        in   synchronous active-high reset (empties the FIFO)
//     push       in   write push_data at the tail
//     push_data  in   WIDTH  entry to write
//     pop        in   retire the head entry
//     flush      in   empty the FIFO; wins over push and pop in the same cycle
//     head_valid out  FIFO is non-empty
//     head_data  out  WIDTH  head entry, zero while empty
//     count      out  clog2(DEPTH)+1  occupancy
//     full       out  occupancy equals DEPTH
// -----------------------------------------------------------------------------
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic                     head_valid,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);

    localparam int                PTR_W      = $clog2(DEPTH);
    localparam logic [PTR_W:0]    FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign full       = (count_q == FULL_COUNT);
    assign head_valid = (count_q != '0);

    // Guards keep the pointers coherent even if a caller misbehaves; a pop
    // in the same cycle frees the slot a full-queue push would need.
    assign do_pop  = pop && !flush && head_valid;
    assign do_push = push && !flush && (!full || do_pop);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of its inputs, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            // Pointers wrap modulo DEPTH for free because DEPTH is a power of two.
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; validity is tracked by
    // count_q alone, and leaving the array out of reset lets it map onto plain
    // RAM/flops without a reset tree.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // Head is masked while empty so downstream never sees stale or unknown data.
    assign head_data = head_valid ? mem[rd_ptr] : '0;
    assign count     = count_q;

endmodule

// File: rtl/ifetch_unit.sv
// -----------------------------------------------------------------------------
// ifetch_unit
//   Instruction fetch unit sitting between the redirect path and the ICache.
//   Generates sequential PCs, keeps at most one ICache read outstanding, and
//   queues returned instructions with their PCs for the decoder. A redirect
//   flushes the queue, marks any in-flight response stale, and restarts fetch.
//
//   Parameters
//     ADDR_WIDTH  : PC / address width
//     QUEUE_DEPTH : instruction queue entries, power of two, >= 2
//     RESET_PC    : first fetch address after reset
//
//   Ports
//     clk               in   clock
//     rst               in   synchronous active-high reset
//     rdy               in   global enable; low freezes all state
//     redirect_valid    in   flush and restart at redirect_pc
//     redirect_pc       in   ADDR_WIDTH  new fetch PC (bits [1:0] ignored)
//     icache_req        out  read request, held until the response
//     icache_addr       out  ADDR_WIDTH  read address, stable while requesting
//     icache_resp_valid in   one-cycle response strobe
//     icache_inst       in   32  response data
//     out_valid         out  queue head valid
//     out_inst          out  32  head instruction
//     out_pc            out  ADDR_WIDTH  head PC
//     out_ready         in   decoder accepts the head
//     queue_count       out  clog2(QUEUE_DEPTH)+1  queue occupancy
// -----------------------------------------------------------------------------
module ifetch_unit
    import ifetch_unit_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    QUEUE_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           rdy,
    input  logic                           redirect_valid,
    input  logic [ADDR_WIDTH-1:0]          redirect_pc,
    output logic                           icache_req,
    output logic [ADDR_WIDTH-1:0]          icache_addr,
    input  logic                           icache_resp_valid,
    input  logic [INST_WIDTH-1:0]          icache_inst,
    output logic                           out_valid,
    output logic [INST_WIDTH-1:0]          out_inst,
    output logic [ADDR_WIDTH-1:0]          out_pc,
    input  logic                           out_ready,
    output logic [$clog2(QUEUE_DEPTH):0]   queue_count
);

    localparam int ENTRY_W = ADDR_WIDTH + INST_WIDTH;

    fetch_state_e          state_q;
    fetch_state_e          state_d;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] pc_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic                  req_q;
    logic                  req_d;

    logic                  q_push;
    logic                  q_pop;
    logic                  q_flush;
    logic                  q_full;
    logic [ENTRY_W-1:0]    q_head;

    logic [ADDR_WIDTH-1:0] redirect_pc_aligned;
    logic                  unused_redirect_lsbs;

    // Fetch addresses are word aligned; the low bits of a redirect target are
    // dropped rather than trusted.
    assign redirect_pc_aligned  = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // ------------------------------------------------------------------
    // Next-state / control logic
    // ------------------------------------------------------------------
    // NOTE: every signal driven here gets a default before any branch, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        req_d   = req_q;
        q_push  = FALSE;
        q_flush = FALSE;

        // With rdy low nothing below is evaluated, so every register holds
        // and redirect/response inputs are ignored.
        if (rdy) begin
            if (redirect_valid) begin
                q_flush = TRUE;
                pc_d    = redirect_pc_aligned;
            end

            unique case (state_q)
                ST_IDLE: begin
                    // Only issue when the response is guaranteed a slot.
                    if (!redirect_valid && !q_full) begin
                        state_d = ST_WAIT;
                        addr_d  = pc_q;
                        req_d   = TRUE;
                    end
                end

                ST_WAIT: begin
                    if (icache_resp_valid) begin
                        // A redirect in the same cycle makes the data stale;
                        // the request is finished either way, so no DROP.
                        state_d = ST_IDLE;
                        req_d   = FALSE;
                        if (!redirect_valid) begin
                            q_push = TRUE;
                            pc_d   = pc_q + ADDR_WIDTH'(PC_STEP);
                        end
                    end else if (redirect_valid) begin
                        // Keep requesting the old address until the cache
                        // answers, then throw that answer away.
                        state_d = ST_DROP;
                    end
                end

                ST_DROP: begin
                    if (icache_resp_valid) begin
                        state_d = ST_IDLE;
                        req_d   = FALSE;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                    req_d   = FALSE;
                end
            endcase
        end
    end

    // Redirect has priority over a pop in the same cycle (flush also wins
    // inside the FIFO; gating here keeps the intent explicit).
    assign q_pop = rdy && out_valid && out_ready && !redirect_valid;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= '0;
            req_q   <= FALSE;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
        end
    end

    assign icache_req  = req_q;
    assign icache_addr = addr_q;

    // ------------------------------------------------------------------
    // Instruction queue: each entry is {pc, instruction}
    // ------------------------------------------------------------------
    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .push       (q_push),
        .push_data  ({pc_q, icache_inst}),
        .pop        (q_pop),
        .flush      (q_flush),
        .head_valid (out_valid),
        .head_data  (q_head),
        .count      (queue_count),
        .full       (q_full)
    );

    assign out_pc   = q_head[ENTRY_W-1:INST_WIDTH];
    assign out_inst = q_head[INST_WIDTH-1:0];

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Parametrised instruction fetch unit between the branch predictor/ROB redirect path and the ICache. It generates sequential PCs, issues one outstanding ICache read at a time, and buffers returned instructions with their PCs in a flushable queue. It presents the instructions to the decoder over a valid/ready handshake. On a redirect it flushes the queue, drops any stale in-flight response, and restarts fetch at the new PC.

## Interface
- ADDR_WIDTH, 32, PC/address width.
- QUEUE_DEPTH, 4, instruction queue entries; power of two, ≥2.
- RESET_PC, 0, first fetch address after reset.

- clk  in  1  system clock.
- rst  in  1  reset: synchronous, active-high. The clock is clk.
- rdy  in  1  global enable; when low, all state freezes.
- redirect_valid  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  ADDR_WIDTH  new fetch PC; bits [1:0] are forced to 0.
- icache_req  out  1  read request, held until the response arrives.
- icache_addr  out  ADDR_WIDTH  read address, stable while icache_req is high.
- icache_resp_valid  in  1  response strobe, one cycle.
- icache_inst  in  32  instruction data, valid with icache_resp_valid.
- out_valid  out  1  queue head is valid.
- out_inst  out  32  head instruction.
- out_pc  out  ADDR_WIDTH  head PC.
- out_ready  in  1  decoder accepts the head.
- queue_count  out  clog2(QUEUE_DEPTH)+1  occupancy, for debug.

## Operation
- FSM states:
  - IDLE: no request outstanding.
  - WAIT: request outstanding, response will be kept.
  - DROP: request outstanding, response will be discarded.
- IDLE → WAIT when queue_count < QUEUE_DEPTH and no redirect this cycle. The block registers icache_req=1 and icache_addr=pc.
- WAIT, icache_resp_valid: push {pc, icache_inst}, set pc ← pc+4 (wraps modulo 2^ADDR_WIDTH), deassert icache_req, go to IDLE.
- WAIT, redirect_valid without a response: go to DROP. icache_req stays high with the old address until the cache answers.
- DROP, icache_resp_valid: discard the data, deassert icache_req, go to IDLE.
- Redirect while in IDLE or DROP: pc ← redirect_pc and flush the queue. The state does not change.
- Redirect and response in the same cycle while in WAIT: discard the response and go to IDLE, not DROP.
- Every redirect flushes the queue in the same cycle. Redirect wins over a simultaneous push or pop.
- A push and a pop in the same cycle leave the count unchanged.
- A request is issued only when there is a free slot, and pops only free slots, so a push never overflows. Pop when empty cannot occur, because out_valid=0.
- Queue pointers wrap modulo QUEUE_DEPTH.
- When rdy=0:
  - The FSM, pc, queue and outputs hold.
  - redirect_valid, icache_resp_valid and out_ready are ignored. The cache must also be stalled by rdy.

## Timing
- Reset values:
  - pc=RESET_PC, state IDLE.
  - icache_req=0, icache_addr=0.
  - Queue empty: out_valid=0, out_inst=0, out_pc=0, queue_count=0.
- The first icache_req is visible in the first cycle after rst falls.
- A response at edge N makes out_valid=1 after edge N+1. The head is driven from registered queue storage with no combinational path from icache_inst.
- The next request issues one cycle after a response, so the maximum throughput is 1 instruction per 2 cycles plus the cache latency.
- After a redirect at edge R, the request to the new PC rises after edge R+1 if the FSM was in IDLE or WAIT-with-response. Otherwise it rises one cycle after the dropped response.
- Pop on the edge where out_valid && out_ready.
- A mid-operation rst abandons the outstanding request. The ICache is reset by the same rst.

## Structure
- Shared package holds:
  - INST_WIDTH=32 and PC_STEP=4.
  - FSM state encodings (IDLE/WAIT/DROP).
  - True/False constants.
- Sub-module fetch_fifo: synchronous FIFO parametrised by width and depth, with push, pop, flush, count and head outputs. ifetch_unit instantiates it with width ADDR_WIDTH+32.

## Test plan
- Reset, RESET_PC=0x100, cache latency 2, out_ready=1 → requests to 0x100, 0x104, 0x108 in order; out_pc matches each address, with out_inst as returned.
- out_ready=0, QUEUE_DEPTH=4 → exactly 4 pushes, queue_count=4, no 5th request. One pop → a request to the 5th PC issues on the next cycle.
- Redirect to 0x2000 while in WAIT for 0x10C → the 0x10C response is dropped, the queue is empty, and the next request goes to 0x2000.
- Redirect to 0x3003 in the same cycle as a response → the response is discarded, and the next address is 0x3000.
- rdy held low for 5 cycles mid-WAIT with out_valid=1 → all outputs are unchanged. After rdy rises, the sequence resumes with no lost or duplicated PC.
- rst asserted while in DROP with 2 queued entries → next cycle out_valid=0, queue_count=0, icache_req=0; the following request goes to RESET_PC.
